// File: rtl/byte_word_packer.sv
// byte_word_packer
//
// Receive-side packer: collects consecutive bytes from an 8-bit stream into a
// BYTES-wide little-endian word and presents each completed word on a
// valid/ready output port. A byte flagged in_last closes the word early.
//
// Ports:
//   clk        single clock, all state on rising edge
//   reset      synchronous, active-high
//   data_in    incoming byte
//   in_valid   data_in/in_last valid this cycle
//   in_last    current byte closes the word
//   in_ready   block can accept a byte (combinational from out_valid/out_ready)
//   data_out   packed word, byte k in bits [8k+7:8k]
//   out_keep   bit k set when lane k holds received data
//   out_valid  data_out/out_keep hold a word
//   out_ready  downstream takes the word this cycle
module byte_word_packer #(
    parameter int unsigned BYTES = 4,
    parameter int unsigned CW    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data_in,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [8*BYTES-1:0]   data_out,
    output logic [BYTES-1:0]     out_keep,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Partial-word state
    logic [8*BYTES-1:0] acc_q, acc_d;
    logic [BYTES-1:0]   acc_keep_q, acc_keep_d;
    logic [CW-1:0]      idx_q, idx_d;

    // Registered output word
    logic [8*BYTES-1:0] data_out_q, data_out_d;
    logic [BYTES-1:0]   out_keep_q, out_keep_d;
    logic               out_valid_q, out_valid_d;

    // Accumulator with the current byte merged into lane idx
    logic [8*BYTES-1:0] merged;
    logic [BYTES-1:0]   merged_keep;

    logic accept;
    logic complete;

    // The output register is free when empty or being drained this edge, so a
    // new word can land on the same edge the old one leaves.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (idx_q == CW'(BYTES - 1)));

    always_comb begin
        merged      = acc_q;
        merged_keep = acc_keep_q;
        for (int unsigned k = 0; k < BYTES; k++) begin
            if (idx_q == CW'(k)) begin
                merged[8*k +: 8] = data_in;
                merged_keep[k]   = 1'b1;
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        acc_keep_d  = acc_keep_q;
        idx_d       = idx_q;
        data_out_d  = data_out_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                // Unwritten lanes read 0 because acc is cleared after every word.
                data_out_d  = merged;
                out_keep_d  = merged_keep;
                out_valid_d = 1'b1;
                acc_d       = '0;
                acc_keep_d  = '0;
                idx_d       = '0;
            end else begin
                acc_d      = merged;
                acc_keep_d = merged_keep;
                idx_d      = idx_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            acc_keep_q  <= '0;
            idx_q       <= '0;
            data_out_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_keep_q  <= acc_keep_d;
            idx_q       <= idx_d;
            data_out_q  <= data_out_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_keep  = out_keep_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

    localparam int unsigned BYTES = 4;
    localparam int unsigned CW    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] data_out;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    byte_word_packer #(
        .BYTES (BYTES),
        .CW    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int vectors     = 0;
    int miscompares = 0;
    int transfers   = 0;

    // Expected words as {keep, data}
    logic [35:0] exp_q[$];

    // Scoreboard consumer: a word leaves whenever out_valid && out_ready.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            logic [35:0] e;
            transfers++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_unexpected_word: got keep=%h data=%h, expected no word",
                         out_keep, data_out);
            end else begin
                e = exp_q.pop_front();
                if ({out_keep, data_out} !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard_word: got keep=%h data=%h, expected keep=%h data=%h",
                             out_keep, data_out, e[35:32], e[31:0]);
                end
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
        in_valid  = v;
        data_in   = d;
        in_last   = l;
        out_ready = r;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
        end
        vectors++;
        if (data_out !== 32'h0) begin
            miscompares++; $display("FAIL reset_data_out: got %h, expected 0", data_out);
        end
        vectors++;
        if (out_keep !== 4'h0) begin
            miscompares++; $display("FAIL reset_out_keep: got %h, expected 0", out_keep);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        step();
    endtask

    task automatic test_stream();
        logic [7:0] b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back({4'hF, 32'h44332211});
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, b[i], 1'b0, 1'b1);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_early_valid: byte %0d got out_valid=%b, expected 0", i, out_valid);
            end
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || data_out !== 32'h44332211 || out_keep !== 4'hF) begin
            miscompares++;
            $display("FAIL stream_word: got v=%b d=%h k=%h, expected v=1 d=44332211 k=f",
                     out_valid, data_out, out_keep);
        end
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL stream_one_cycle: got out_valid=%b, expected 0", out_valid);
        end
        step();
    endtask

    task automatic test_early_last();
        exp_q.push_back({4'h3, 32'h0000BBAA});
        drive(1'b1, 8'hAA, 1'b0, 1'b1);
        step();
        drive(1'b1, 8'hBB, 1'b1, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || data_out !== 32'h0000BBAA || out_keep !== 4'h3) begin
            miscompares++;
            $display("FAIL early_last_word: got v=%b d=%h k=%h, expected v=1 d=0000bbaa k=3",
                     out_valid, data_out, out_keep);
        end
        step();
        // Single-byte word must start at lane 0 with upper lanes zero.
        exp_q.push_back({4'h1, 32'h000000C7});
        drive(1'b1, 8'hC7, 1'b1, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || data_out !== 32'h000000C7 || out_keep !== 4'h1) begin
            miscompares++;
            $display("FAIL one_byte_word: got v=%b d=%h k=%h, expected v=1 d=000000c7 k=1",
                     out_valid, data_out, out_keep);
        end
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
    endtask

    task automatic test_backpressure();
        exp_q.push_back({4'hF, 32'h04030201});
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            step();
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 8'h05, 1'b0, 1'b0);
            vectors++;
            if (out_valid !== 1'b1 || data_out !== 32'h04030201 || out_keep !== 4'hF
                || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_cycle_%0d: got v=%b d=%h k=%h rdy=%b, expected v=1 d=04030201 k=f rdy=0",
                         c, out_valid, data_out, out_keep, in_ready);
            end
            step();
        end
        exp_q.push_back({4'hF, 32'h08070605});
        drive(1'b1, 8'h05, 1'b0, 1'b1);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL stall_release_ready: got %b, expected 1", in_ready);
        end
        step();
        for (int i = 6; i <= 8; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || data_out !== 32'h08070605) begin
            miscompares++;
            $display("FAIL stall_next_word: got v=%b d=%h, expected v=1 d=08070605", out_valid, data_out);
        end
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
    endtask

    task automatic test_back_to_back();
        exp_q.push_back({4'hF, 32'h04030201});
        exp_q.push_back({4'hF, 32'h08070605});
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1'b1, 8'(i + 1), 1'b0, 1'b1);
            else       drive(1'b0, 8'h00, 1'b0, 1'b1);
            vectors++;
            if (out_valid !== ((i == 4) || (i == 8)) || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_cycle_%0d: got v=%b rdy=%b, expected v=%b rdy=1",
                         i, out_valid, in_ready, ((i == 4) || (i == 8)));
            end
            step();
        end
    endtask

    task automatic test_simultaneous();
        int t0;
        exp_q.push_back({4'hF, 32'h14131211});
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            step();
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 8'h21, 1'b1, 1'b0);
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL simul_stall_%0d: got rdy=%b v=%b, expected rdy=0 v=1", c, in_ready, out_valid);
            end
            step();
        end
        t0 = transfers;
        exp_q.push_back({4'h1, 32'h00000021});
        drive(1'b1, 8'h21, 1'b1, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || data_out !== 32'h00000021 || out_keep !== 4'h1) begin
            miscompares++;
            $display("FAIL simul_new_word: got v=%b d=%h k=%h, expected v=1 d=00000021 k=1",
                     out_valid, data_out, out_keep);
        end
        step();
        vectors++;
        if (transfers - t0 !== 1) begin
            miscompares++;
            $display("FAIL simul_consumed_once: got %0d transfers, expected 1", transfers - t0);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL simul_drain: got out_valid=%b, expected 0", out_valid);
        end
        step();
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            logic rdy;
            rdy = (pass == 0);
            // Pass 0: reset after two bytes. Pass 1: reset during an output stall.
            for (int i = 0; i < ((pass == 0) ? 2 : 4); i++) begin
                drive(1'b1, 8'(8'h31 + i), 1'b0, rdy);
                step();
            end
            if (pass == 1) begin
                drive(1'b0, 8'h00, 1'b0, 1'b0);
                step();
            end
            reset = 1'b1;
            drive(1'b0, 8'h00, 1'b0, rdy);
            step();
            reset = 1'b0;
            drive(1'b0, 8'h00, 1'b0, rdy);
            vectors++;
            if (out_valid !== 1'b0 || data_out !== 32'h0 || out_keep !== 4'h0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_mid_%0d: got v=%b d=%h k=%h rdy=%b, expected v=0 d=0 k=0 rdy=1",
                         pass, out_valid, data_out, out_keep, in_ready);
            end
            exp_q.push_back({4'hF, 32'h44434241 + (pass * 32'h20202020)});
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, 8'(8'h41 + 8'h20 * pass + i), 1'b0, 1'b1);
                step();
            end
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            vectors++;
            if (out_valid !== 1'b1 || data_out !== 32'h44434241 + (pass * 32'h20202020)
                || out_keep !== 4'hF) begin
                miscompares++;
                $display("FAIL reset_mid_word_%0d: got v=%b d=%h k=%h, expected v=1 d=%h k=f",
                         pass, out_valid, data_out, out_keep, 32'h44434241 + (pass * 32'h20202020));
            end
            step();
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            step();
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        data_in  = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_stream();
        test_early_last();
        test_backpressure();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drained: got %0d words outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
